multi_zone_bbox_detector: RTL



---
 rtl/multi_zone_bbox_detector_pkg.sv | 22 ++
 rtl/zone_bbox_accum.sv | 87 ++++++++
 rtl/multi_zone_bbox_detector.sv | 104 ++++++++++
 3 files changed

// File: rtl/multi_zone_bbox_detector_pkg.sv
// Shared constants and helpers for the multi-zone bounding-box detector.
// Zone boundaries are derived from constants so zone decode needs no divider.
package multi_zone_bbox_detector_pkg;

    localparam int COORD_W_DEF = 11;
    localparam int CNT_W_DEF   = 20;

    // Inclusive column range owned by zone z when each zone is zw pixels wide.
    function automatic int zone_lo(input int z, input int zw);
        return z * zw;
    endfunction

    function automatic int zone_hi(input int z, input int zw);
        return (z + 1) * zw - 1;
    endfunction

    // Low bit of entry idx in a packed vector of w-bit entries.
    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/zone_bbox_accum.sv
// One zone's bounding-box accumulator with frame-level hit/miss hysteresis.
// A pixel arriving in the frame-close cycle seeds the next frame's accumulators.
module zone_bbox_accum
    import multi_zone_bbox_detector_pkg::*;
#(
    parameter int COORD_W     = COORD_W_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int MIN_PIXELS  = 16,
    parameter int HOLD_FRAMES = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_valid,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    input  logic               frame_close,
    output logic [COORD_W-1:0] rect_up,
    output logic [COORD_W-1:0] rect_down,
    output logic [COORD_W-1:0] rect_left,
    output logic [COORD_W-1:0] rect_right,
    output logic               rect_valid
);

    localparam int HC_W = $clog2(HOLD_FRAMES + 1);
    localparam logic [HC_W-1:0] HOLD = HC_W'(HOLD_FRAMES);

    logic [COORD_W-1:0] min_x, max_x, min_y, max_y;
    logic [CNT_W-1:0]   count;
    logic [HC_W-1:0]    hit_cnt, miss_cnt, hit_cnt_n, miss_cnt_n;
    logic               hit, valid_n;

    assign hit = (count >= CNT_W'(MIN_PIXELS));

    always_comb begin
        hit_cnt_n  = hit_cnt;
        miss_cnt_n = miss_cnt;
        valid_n    = rect_valid;
        if (hit) begin
            hit_cnt_n  = (hit_cnt == HOLD) ? HOLD : hit_cnt + HC_W'(1);
            miss_cnt_n = '0;
            if (hit_cnt_n == HOLD) valid_n = 1'b1;
        end else begin
            miss_cnt_n = (miss_cnt == HOLD) ? HOLD : miss_cnt + HC_W'(1);
            hit_cnt_n  = '0;
            if (miss_cnt_n == HOLD) valid_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_x      <= '1;
            min_y      <= '1;
            max_x      <= '0;
            max_y      <= '0;
            count      <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            rect_up    <= '0;
            rect_down  <= '0;
            rect_left  <= '0;
            rect_right <= '0;
            rect_valid <= 1'b0;
        end else if (frame_close) begin
            min_x      <= pix_valid ? pix_x : '1;
            min_y      <= pix_valid ? pix_y : '1;
            max_x      <= pix_valid ? pix_x : '0;
            max_y      <= pix_valid ? pix_y : '0;
            count      <= pix_valid ? CNT_W'(1) : '0;
            hit_cnt    <= hit_cnt_n;
            miss_cnt   <= miss_cnt_n;
            rect_valid <= valid_n;
            if (hit) begin
                rect_up    <= min_y;
                rect_down  <= max_y;
                rect_left  <= min_x;
                rect_right <= max_x;
            end
        end else if (pix_valid) begin
            if (pix_x < min_x) min_x <= pix_x;
            if (pix_x > max_x) max_x <= pix_x;
            if (pix_y < min_y) min_y <= pix_y;
            if (pix_y > max_y) max_y <= pix_y;
            if (count != '1)   count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/multi_zone_bbox_detector.sv
// Splits the mask stream into N_ZONES vertical columns and tracks one box per zone.
// Owns sync edge detection, the pixel coordinate counters and the zone decode.
module multi_zone_bbox_detector
    import multi_zone_bbox_detector_pkg::*;
#(
    parameter int IMG_HDISP   = 960,
    parameter int IMG_VDISP   = 540,
    parameter int COORD_W     = COORD_W_DEF,
    parameter int N_ZONES     = 4,
    parameter int MIN_PIXELS  = 16,
    parameter int HOLD_FRAMES = 3,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       per_frame_vsync,
    input  logic                       per_frame_href,
    input  logic                       per_frame_clken,
    input  logic                       per_img_bit,
    output logic [N_ZONES*COORD_W-1:0] rect_up,
    output logic [N_ZONES*COORD_W-1:0] rect_down,
    output logic [N_ZONES*COORD_W-1:0] rect_left,
    output logic [N_ZONES*COORD_W-1:0] rect_right,
    output logic [N_ZONES-1:0]         rect_valid,
    output logic                       frame_done
);

    localparam int ZW = IMG_HDISP / N_ZONES;

    if ((IMG_HDISP % N_ZONES) != 0) begin : g_bad_zone_split
        $error("IMG_HDISP must be divisible by N_ZONES");
    end

    logic               vsync_d, href_d, vs_rise, href_fall, pix_valid;
    logic [COORD_W-1:0] x, y;
    logic [N_ZONES-1:0] zone_pix;

    assign vs_rise   = per_frame_vsync & ~vsync_d;
    assign href_fall = ~per_frame_href & href_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d    <= 1'b0;
            href_d     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            vsync_d    <= per_frame_vsync;
            href_d     <= per_frame_href;
            frame_done <= vs_rise;
        end
    end

    // y saturates at IMG_VDISP so trailing blank lines stay out of range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (vs_rise) begin
            x <= '0;
            y <= '0;
        end else begin
            if (href_fall)
                x <= '0;
            else if (per_frame_clken && per_frame_href)
                x <= x + COORD_W'(1);
            if (href_fall && (y != COORD_W'(IMG_VDISP)))
                y <= y + COORD_W'(1);
        end
    end

    assign pix_valid = per_frame_clken & per_frame_href & per_img_bit &
                       (x < COORD_W'(IMG_HDISP)) & (y < COORD_W'(IMG_VDISP));

    for (genvar z = 0; z < N_ZONES; z++) begin : g_zone
        localparam int LO = zone_lo(z, ZW);
        localparam int HI = zone_hi(z, ZW);

        if (z == 0) begin : g_first
            assign zone_pix[z] = pix_valid && (x <= COORD_W'(HI));
        end else begin : g_rest
            assign zone_pix[z] = pix_valid && (x >= COORD_W'(LO)) && (x <= COORD_W'(HI));
        end

        zone_bbox_accum #(
            .COORD_W     (COORD_W),
            .CNT_W       (CNT_W),
            .MIN_PIXELS  (MIN_PIXELS),
            .HOLD_FRAMES (HOLD_FRAMES)
        ) u_accum (
            .clk         (clk),
            .rst_n       (rst_n),
            .pix_valid   (zone_pix[z]),
            .pix_x       (x),
            .pix_y       (y),
            .frame_close (vs_rise),
            .rect_up     (rect_up[slice_lo(z, COORD_W) +: COORD_W]),
            .rect_down   (rect_down[slice_lo(z, COORD_W) +: COORD_W]),
            .rect_left   (rect_left[slice_lo(z, COORD_W) +: COORD_W]),
            .rect_right  (rect_right[slice_lo(z, COORD_W) +: COORD_W]),
            .rect_valid  (rect_valid[z])
        );
    end

endmodule
